// File: rtl/la_arbmux2_if.sv
// rtl/la_arbmux2_if.sv - two-source packet stream bundle for the la_arbmux2 arbiter
interface la_arbmux2_if #(
  parameter int DW = 32
);
  logic          in0_valid;
  logic [DW-1:0] in0_data;
  logic          in0_last;
  logic          in0_ready;
  logic          in1_valid;
  logic [DW-1:0] in1_data;
  logic          in1_last;
  logic          in1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [1:0]    grant;
  logic          busy;

  modport slave (
    input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_last, grant, busy
  );

  modport master (
    output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_last, grant, busy
  );
endinterface

// File: rtl/la_arbmux2.sv
// rtl/la_arbmux2.sv - two-requester packet arbiter with 2:1 data mux and registered output
module la_arbmux2 #(
  parameter int DW   = 32,
  parameter int RR   = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  la_arbmux2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic          can_accept;
  logic          rdy0, rdy1;
  logic          accept;
  logic          sel;
  logic [DW-1:0] mux_data;
  logic          mux_last;

  // ptr holds the last winner, so a tie goes to the other requester
  function automatic state_t arb(input logic v0, input logic v1, input logic p);
    state_t s;
    if (v0 && v1)   s = (RR != 0) ? (p ? OWN0 : OWN1) : OWN0;
    else if (v0)    s = OWN0;
    else if (v1)    s = OWN1;
    else            s = IDLE;
    return s;
  endfunction

  assign sel = (state_q == OWN1);

  generate
    if (PROP == "DEFAULT") begin : g_mux_sel
      assign mux_data = sel ? bus.in1_data : bus.in0_data;
      assign mux_last = sel ? bus.in1_last : bus.in0_last;
    end else begin : g_mux_andor
      assign mux_data = ({DW{sel}} & bus.in1_data) | ({DW{~sel}} & bus.in0_data);
      assign mux_last = (sel & bus.in1_last) | (~sel & bus.in0_last);
    end
  endgenerate

  always_comb begin
    can_accept  = ~out_valid_q | bus.out_ready;
    rdy0        = (state_q == OWN0) & can_accept;
    rdy1        = (state_q == OWN1) & can_accept;
    accept      = (rdy0 & bus.in0_valid) | (rdy1 & bus.in1_valid);
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    // Rearbitrating in the last-beat cycle avoids a bubble between packets
    if ((state_q == IDLE) || (accept && mux_last)) begin
      state_d = arb(bus.in0_valid, bus.in1_valid, ptr_q);
      if (state_d == OWN0) ptr_d = 1'b0;
      if (state_d == OWN1) ptr_d = 1'b1;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = mux_last;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in0_ready = rdy0;
  assign bus.in1_ready = rdy1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.grant     = {state_q == OWN1, state_q == OWN0};
  assign bus.busy      = (state_q != IDLE);

endmodule
